// File: rtl/ecap5_dwbgpio_if.sv
// ecap5_dwbgpio_if: Wishbone pipelined bus between the interconnect (master) and the GPIO slave
interface ecap5_dwbgpio_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_stall_o;
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/ecap5_dwbgpio.sv
// ecap5_dwbgpio: Wishbone GPIO slave with LED output register and debounced, edge-latched button inputs
module ecap5_dwbgpio #(
    parameter int NB_OUT          = 2,
    parameter int NB_IN           = 2,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int CNT_W           = 16
)(
    input  logic               clk_i,
    input  logic               rst_i,
    ecap5_dwbgpio_if.slave     wb,
    input  logic [NB_IN-1:0]   gpio_i,
    output logic [NB_OUT-1:0]  gpio_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic              req, wr;
    logic [1:0]        reg_sel;
    logic [31:0]       lane_mask, out_full, rd_data, dat_q;
    logic              ack_q;
    logic [NB_OUT-1:0] out_q, out_d;
    logic [NB_IN-1:0]  sync1_q, sync2_q, in_q, in_d, in_prev_q, edge_q, edge_d, clr;
    logic [CNT_W-1:0]  cnt_q [NB_IN];
    logic [CNT_W-1:0]  cnt_d [NB_IN];
    logic              unused_bits;
    assign req         = wb.wb_cyc_i & wb.wb_stb_i;
    assign wr          = req & wb.wb_we_i;
    assign reg_sel     = wb.wb_adr_i[3:2];
    assign lane_mask   = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}}, {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign wb.wb_stall_o = 1'b0;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign gpio_o      = out_q;
    assign unused_bits = ^{out_full, lane_mask, wb.wb_adr_i, wb.wb_dat_i};
    // Register writes (byte-lane merge, W1C with rising edge taking priority) and read mux
    always_comb begin
        out_full = (32'(out_q) & ~lane_mask) | (wb.wb_dat_i & lane_mask);
        out_d    = (wr && reg_sel == 2'd0) ? out_full[NB_OUT-1:0] : out_q;
        clr      = (wr && reg_sel == 2'd2) ? wb.wb_dat_i[NB_IN-1:0] & lane_mask[NB_IN-1:0] : '0;
        edge_d   = (edge_q & ~clr) | (in_q & ~in_prev_q);
        rd_data  = reg_sel == 2'd0 ? 32'(out_q) :
                   reg_sel == 2'd1 ? 32'(in_q)  :
                   reg_sel == 2'd2 ? 32'(edge_q) : 32'd0;
    end
    // Per-bit debounce: accept the synced level once it has differed for DEBOUNCE_CYCLES samples
    always_comb begin
        in_d = in_q;
        for (int i = 0; i < NB_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != in_q[i]) begin
                if (cnt_q[i] == CNT_MAX) in_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
    // Bus pipeline: one-cycle registered ack and read data, register state update
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            out_q  <= '0;
            edge_q <= '0;
        end else begin
            ack_q  <= req;
            dat_q  <= (req && !wb.wb_we_i) ? rd_data : '0;
            out_q  <= out_d;
            edge_q <= edge_d;
        end
    end
    // Input path: two-flop synchroniser, debounced level and its previous value for edge detect
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            in_q      <= '0;
            in_prev_q <= '0;
            for (int i = 0; i < NB_IN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= gpio_i;
            sync2_q   <= sync1_q;
            in_q      <= in_d;
            in_prev_q <= in_q;
            for (int i = 0; i < NB_IN; i++) cnt_q[i] <= cnt_d[i];
        end
    end
endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// tb_ecap5_dwbgpio: directed bench with a behavioural GPIO model checked every cycle
module tb_ecap5_dwbgpio;
    localparam int DEB = 8;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] gpio_i = 2'b11;
    logic [1:0] gpio_o;
    int         total = 0;
    int         bad = 0;
    ecap5_dwbgpio_if bus();
    ecap5_dwbgpio #(.NB_OUT(2), .NB_IN(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .wb(bus), .gpio_i(gpio_i), .gpio_o(gpio_o)
    );
    always #5 clk = ~clk;
    // Behavioural model: run-length of synced samples decides when IN adopts a new level
    logic        m_ack, m_req;
    logic [31:0] m_dat;
    logic [1:0]  m_out, m_in, m_in_prev, m_edge, m_s1, m_s2, m_last, m_a;
    int          m_run [2];
    int          nrun [2];
    assign m_req = bus.wb_cyc_i & bus.wb_stb_i;
    assign m_a   = bus.wb_adr_i[3:2];
    function automatic logic [31:0] mreg(input logic [1:0] a);
        return a == 2'd0 ? {30'b0, m_out} : a == 2'd1 ? {30'b0, m_in} : a == 2'd2 ? {30'b0, m_edge} : 32'b0;
    endfunction
    always_comb for (int b = 0; b < 2; b++) nrun[b] = (m_s2[b] == m_last[b]) ? m_run[b] + 1 : 1;
    always @(posedge clk) begin
        if (!rst_i) begin
            m_ack <= 1'b0; m_dat <= 32'b0; m_out <= 2'b0; m_in <= 2'b0; m_in_prev <= 2'b0;
            m_edge <= 2'b0; m_s1 <= 2'b0; m_s2 <= 2'b0; m_last <= 2'b0;
            m_run[0] <= 0; m_run[1] <= 0;
        end else begin
            m_ack <= m_req;
            m_dat <= (m_req && !bus.wb_we_i) ? mreg(m_a) : 32'b0;
            if (m_req && bus.wb_we_i && m_a == 2'd0 && bus.wb_sel_i[0]) m_out <= bus.wb_dat_i[1:0];
            m_s1 <= gpio_i; m_s2 <= m_s1; m_last <= m_s2; m_in_prev <= m_in;
            for (int b = 0; b < 2; b++) begin
                m_run[b] <= nrun[b];
                if (m_s2[b] != m_in[b] && nrun[b] >= DEB) m_in[b] <= m_s2[b];
                m_edge[b] <= (m_in[b] && !m_in_prev[b]) ||
                             (m_edge[b] && !(m_req && bus.wb_we_i && m_a == 2'd2 && bus.wb_sel_i[0] && bus.wb_dat_i[b]));
            end
        end
    end
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask
    // Cycle-by-cycle comparison of the DUT outputs against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ack", {31'b0, bus.wb_ack_o}, {31'b0, m_ack});
            chk("dat", bus.wb_dat_o, m_dat);
            chk("gpio", {30'b0, gpio_o}, {30'b0, m_out});
            chk("stall", {31'b0, bus.wb_stall_o}, 32'b0);
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
    task automatic drive(input logic [31:0] a, d, input logic [3:0] s, input logic w);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s; bus.wb_we_i = w;
    endtask
    task automatic idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask
    task automatic xfer(input logic [31:0] a, d, input logic [3:0] s, input logic w);
        @(posedge clk); #2; drive(a, d, s, w);
        @(posedge clk); #2; idle();
        @(negedge clk); #1;
    endtask
    task automatic rd(input logic [31:0] a, exp, input string n);
        xfer(a, 32'b0, 4'b0, 1'b0);
        chk({n, "_ack"}, {31'b0, bus.wb_ack_o}, 32'd1);
        chk(n, bus.wb_dat_o, exp);
    endtask
    task automatic wr(input logic [31:0] a, d, input logic [3:0] s, input string n);
        xfer(a, d, s, 1'b1);
        chk({n, "_ack"}, {31'b0, bus.wb_ack_o}, 32'd1);
        chk({n, "_dat"}, bus.wb_dat_o, 32'd0);
    endtask
    logic [31:0] b2b_adr [3] = '{32'h0, 32'h0, 32'hC};
    logic [31:0] b2b_exp [3] = '{32'h0, 32'h3, 32'h0};
    logic [31:0] db_adr  [4] = '{32'h4, 32'h8, 32'h8, 32'h4};
    logic [31:0] db_exp  [4] = '{32'h0, 32'h0, 32'h1, 32'h1};
    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; idle();
        // reset held for three clocks with buttons pressed
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gpio", {30'b0, gpio_o}, 32'd0);
        chk("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        rst_i = 1'b1; gpio_i = 2'b00;
        rd(32'h4, 32'h0, "rst_in");
        rd(32'h8, 32'h0, "rst_edge");
        // OUT writes with and without the lane enable
        wr(32'h0, 32'h3, 4'b0001, "w_out");
        chk("gpio_w_out", {30'b0, gpio_o}, 32'd3);
        wr(32'h0, 32'h0, 4'b0000, "w_nosel");
        chk("gpio_w_nosel", {30'b0, gpio_o}, 32'd3);
        // back-to-back: write 0x0, read 0x0, read 0xC
        @(posedge clk); #2; drive(32'h0, 32'h3, 4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            if (k < 2) begin bus.wb_we_i = 1'b0; bus.wb_adr_i = b2b_adr[k+1]; end
            else idle();
            @(negedge clk); #1;
            chk("b2b_ack", {31'b0, bus.wb_ack_o}, 32'd1);
            chk("b2b_dat", bus.wb_dat_o, b2b_exp[k]);
        end
        @(negedge clk); #1;
        chk("b2b_idle", {31'b0, bus.wb_ack_o}, 32'd0);
        // 5-cycle glitch is rejected
        @(posedge clk); #2; gpio_i = 2'b01;
        repeat (5) @(posedge clk);
        #2; gpio_i = 2'b00;
        repeat (15) @(posedge clk);
        rd(32'h4, 32'h0, "glitch_in");
        // held press: IN rises 10 cycles after the pin, EDGE one cycle later
        @(posedge clk); #2; gpio_i = 2'b01;
        repeat (9) @(posedge clk);
        #2;
        chk("model_in_e9", {31'b0, m_in[0]}, 32'd0);
        drive(db_adr[0], 32'h0, 4'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            if (k < 3) bus.wb_adr_i = db_adr[k+1];
            else idle();
            @(negedge clk); #1;
            if (k == 0) begin
                chk("model_in_e10", {31'b0, m_in[0]}, 32'd1);
                chk("model_edge_e10", {31'b0, m_edge[0]}, 32'd0);
            end
            if (k == 1) chk("model_edge_e11", {31'b0, m_edge[0]}, 32'd1);
            chk("db_ack", {31'b0, bus.wb_ack_o}, 32'd1);
            chk("db_dat", bus.wb_dat_o, db_exp[k]);
        end
        gpio_i = 2'b00;
        repeat (20) @(posedge clk);
        rd(32'h4, 32'h0, "fall_in");
        rd(32'h8, 32'h1, "fall_edge");
        // W1C of bit 0 only
        @(posedge clk); #2; gpio_i = 2'b11;
        repeat (15) @(posedge clk);
        rd(32'h8, 32'h3, "edge_both");
        wr(32'h8, 32'h1, 4'b0001, "w1c");
        rd(32'h8, 32'h2, "w1c_edge");
        rd(32'h4, 32'h3, "in_both");
        @(posedge clk); #2; gpio_i = 2'b10;
        repeat (15) @(posedge clk);
        rd(32'h4, 32'h2, "in_drop");
        rd(32'h8, 32'h2, "edge_nofall");
        // clear of bit 0 coincides with its new rising edge: set wins
        @(posedge clk); #2; gpio_i = 2'b11;
        repeat (10) @(posedge clk);
        #2; drive(32'h8, 32'h1, 4'b0001, 1'b1);
        @(posedge clk); #2; idle();
        @(negedge clk); #1;
        chk("race_ack", {31'b0, bus.wb_ack_o}, 32'd1);
        rd(32'h8, 32'h3, "race_edge");
        // reset asserted on the edge a read is accepted
        @(posedge clk); #2; drive(32'h0, 32'h0, 4'b0, 1'b0); rst_i = 1'b0;
        @(posedge clk); #2; idle();
        @(negedge clk); #1;
        chk("rstmid_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        chk("rstmid_dat", bus.wb_dat_o, 32'd0);
        chk("rstmid_gpio", {30'b0, gpio_o}, 32'd0);
        @(posedge clk); #2; rst_i = 1'b1; gpio_i = 2'b00;
        rd(32'h0, 32'h0, "rstmid_out");
        rd(32'h4, 32'h0, "rstmid_in");
        rd(32'h8, 32'h0, "rstmid_edge");
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
